// File: rtl/cache_pkg.sv
// Shared constants, types and responder state encoding for the read-only
// cache-line interface.
package cache_pkg;

  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int W_OFFSET   = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W      = $clog2(BEATS);

  // Clears the byte-offset bits so every burst starts on a line boundary.
  localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << W_OFFSET) - 32'd1);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESP,
    DONE
  } state_e;

endpackage

// File: rtl/line_assembler.sv
// Collects memory beats into a cache line: beat counter plus one register
// slot per beat, beat 0 in the least-significant bits.
module line_assembler
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  last_beat,
  output logic [LINE_WIDTH-1:0] line
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_beat = beat_valid && (cnt_q == CNT_W'(BEATS - 1));

  // Saturates on the final beat; the next request clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat_valid && !last_beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [BEAT_WIDTH-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (beat_valid && (cnt_q == CNT_W'(gi))) begin
        slot_d = beat_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign line[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_q;
  end

endmodule

// File: rtl/ro_line_responder.sv
// Serves one read-only cache-line request by fetching the line from memory as
// a burst of beats and returning it with a single-cycle resp pulse.
module ro_line_responder
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           line_addr,
  input  logic                  line_read,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [31:0]           burst_addr,
  output logic                  burst_read,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  state_e                  state_q, state_d;
  logic [31:0]             burst_addr_q, burst_addr_d;
  logic                    burst_read_q, burst_read_d;
  logic                    line_resp_q, line_resp_d;
  logic [LINE_WIDTH-1:0]   line_rdata_q, line_rdata_d;
  logic                    abort_q, abort_d;

  logic                    clear;
  logic                    beat_valid;
  logic                    last_beat;
  logic [LINE_WIDTH-1:0]   asm_line;

  // Beats outside BURST never reach the assembler.
  assign beat_valid = burst_resp && (state_q == BURST);

  line_assembler u_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .beat_valid (beat_valid),
    .beat_data  (burst_rdata),
    .last_beat  (last_beat),
    .line       (asm_line)
  );

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    burst_read_d = burst_read_q;
    line_resp_d  = 1'b0;
    line_rdata_d = line_rdata_q;
    abort_d      = abort_q;
    clear        = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_read) begin
          burst_addr_d = line_addr & LINE_ADDR_MASK;
          burst_read_d = 1'b1;
          abort_d      = 1'b0;
          clear        = 1'b1;
          state_d      = BURST;
        end
      end
      BURST: begin
        // Memory cannot abort a burst, so a dropped request only silences RESP.
        if (!line_read) begin
          abort_d = 1'b1;
        end
        if (last_beat) begin
          burst_read_d = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (!abort_q && line_read) begin
          line_resp_d  = 1'b1;
          line_rdata_d = asm_line;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      burst_read_q <= 1'b0;
      line_resp_q  <= 1'b0;
      line_rdata_q <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      burst_read_q <= burst_read_d;
      line_resp_q  <= line_resp_d;
      line_rdata_q <= line_rdata_d;
      abort_q      <= abort_d;
    end
  end

  assign line_rdata = line_rdata_q;
  assign line_resp  = line_resp_q;
  assign burst_addr = burst_addr_q;
  assign burst_read = burst_read_q;

endmodule

// File: tb/tb_ro_line_responder.sv
// Directed bench for ro_line_responder: drives requests and memory beats and
// checks timing, addressing and assembled data against hand-computed values.
module tb_ro_line_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  line_addr;
  logic         line_read;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_addr;
  logic         burst_read;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int errors = 0;
  int checks = 0;

  logic [63:0] beat_vals [4];

  ro_line_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_addr  (burst_addr),
    .burst_read  (burst_read),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  always #5 clk = ~clk;

  // Issues a request at the current negedge and plays the memory side.
  // k counts sampling cycles after the edge that sees the request.
  // br_bad counts cycles where burst_read differs from "high for k < last beat edge".
  task automatic drive_line(input logic [31:0] addr, input int gap, input int drop_after,
                            input bit spur, input bit rereq,
                            output int resp_at, output int resp_cnt,
                            output logic [255:0] got, output logic [31:0] baddr,
                            output int br_bad);
    int last_k;
    int nb;
    last_k   = 4 * (gap + 1);
    nb       = 0;
    resp_at  = -1;
    resp_cnt = 0;
    got      = '0;
    baddr    = '0;
    br_bad   = 0;
    line_addr  = addr;
    line_read  = 1'b1;
    burst_resp = 1'b0;
    for (int k = 0; k <= last_k + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        baddr     = burst_addr;
        line_addr = ~addr;
      end
      if (line_resp === 1'b1) begin
        if (resp_at < 0) resp_at = k;
        resp_cnt++;
        got       = line_rdata;
        line_read = 1'b0;
      end
      if ((k < last_k) != (burst_read === 1'b1)) br_bad++;
      if (drop_after > 0 && nb >= drop_after) line_read = 1'b0;
      burst_resp  = 1'b0;
      burst_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      if (((k + 1) % (gap + 1) == 0) && nb < 4) begin
        burst_resp  = 1'b1;
        burst_rdata = beat_vals[nb];
        nb++;
      end else if (spur && k >= last_k) begin
        burst_resp = 1'b1;
      end
      if (rereq && k == last_k + 1) begin
        line_addr = addr;
        line_read = 1'b1;
      end
    end
    burst_resp = 1'b0;
    $display("txn addr=%08h gap=%0d drop=%0d baddr=%08h resp_at=%0d resp_cnt=%0d br_bad=%0d data=%064h",
             addr, gap, drop_after, baddr, resp_at, resp_cnt, br_bad, got);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    line_read   = 1'b0;
    line_addr   = 32'h0;
    burst_resp  = 1'b0;
    burst_rdata = 64'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (burst_read !== 1'b0) begin errors++; $display("FAIL reset_burst_read got=%b exp=0", burst_read); end
    checks++;
    if (line_resp !== 1'b0) begin errors++; $display("FAIL reset_line_resp got=%b exp=0", line_resp); end
    checks++;
    if (line_rdata !== 256'h0) begin errors++; $display("FAIL reset_line_rdata got=%064h exp=0", line_rdata); end
    checks++;
    if (burst_addr !== 32'h0) begin errors++; $display("FAIL reset_burst_addr got=%08h exp=0", burst_addr); end
    $display("txn reset: burst_read=%b line_resp=%b burst_addr=%08h", burst_read, line_resp, burst_addr);
  endtask

  task automatic test_basic_line();
    int ra, rc, bb;
    logic [255:0] got, exp_line;
    logic [31:0]  ba;
    beat_vals[0] = 64'h1111_1111_1111_1111;
    beat_vals[1] = 64'h2222_2222_2222_2222;
    beat_vals[2] = 64'h3333_3333_3333_3333;
    beat_vals[3] = 64'h4444_4444_4444_4444;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    drive_line(32'h0000_1234, 0, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (ba !== 32'h0000_1220) begin errors++; $display("FAIL basic_burst_addr got=%08h exp=00001220", ba); end
    checks++;
    if (ra !== 5) begin errors++; $display("FAIL basic_resp_cycle got=%0d exp=5", ra); end
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL basic_resp_width got=%0d exp=1", rc); end
    checks++;
    if (got !== exp_line) begin errors++; $display("FAIL basic_line_rdata got=%064h exp=%064h", got, exp_line); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL basic_burst_read got=%0d bad cycles exp=0", bb); end
    checks++;
    if (line_rdata !== exp_line) begin errors++; $display("FAIL basic_rdata_hold got=%064h exp=%064h", line_rdata, exp_line); end
  endtask

  task automatic test_gapped_line();
    int ra, rc, bb;
    logic [255:0] got, exp_line;
    logic [31:0]  ba;
    beat_vals[0] = 64'h1111_1111_1111_1111;
    beat_vals[1] = 64'h2222_2222_2222_2222;
    beat_vals[2] = 64'h3333_3333_3333_3333;
    beat_vals[3] = 64'h4444_4444_4444_4444;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    repeat (2) @(negedge clk);
    drive_line(32'h0000_1234, 2, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (ra !== 13) begin errors++; $display("FAIL gap_resp_cycle got=%0d exp=13", ra); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL gap_burst_read got=%0d bad cycles exp=0", bb); end
    checks++;
    if (got !== exp_line) begin errors++; $display("FAIL gap_line_rdata got=%064h exp=%064h", got, exp_line); end
  endtask

  task automatic test_spurious();
    int ra, rc, bb;
    logic [255:0] got, prev_line, exp_a, exp_b;
    logic [31:0]  ba;
    prev_line = line_rdata;
    line_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(i);
    end
    @(negedge clk);
    burst_resp = 1'b0;
    checks++;
    if (burst_read !== 1'b0) begin errors++; $display("FAIL spur_idle_burst_read got=%b exp=0", burst_read); end
    checks++;
    if (line_resp !== 1'b0) begin errors++; $display("FAIL spur_idle_line_resp got=%b exp=0", line_resp); end
    checks++;
    if (line_rdata !== prev_line) begin errors++; $display("FAIL spur_idle_rdata got=%064h exp=%064h", line_rdata, prev_line); end
    $display("txn spurious beats in idle: burst_read=%b line_resp=%b", burst_read, line_resp);

    beat_vals[0] = 64'hAAAA_0000_0000_000A;
    beat_vals[1] = 64'hBBBB_0000_0000_000B;
    beat_vals[2] = 64'hCCCC_0000_0000_000C;
    beat_vals[3] = 64'hDDDD_0000_0000_000D;
    exp_a = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
             64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    drive_line(32'h0000_0100, 0, 0, 1'b1, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (got !== exp_a || ra !== 5) begin
      errors++; $display("FAIL spur_line_a got=%064h@%0d exp=%064h@5", got, ra, exp_a);
    end

    beat_vals[0] = 64'h0123_4567_89AB_CDEF;
    beat_vals[1] = 64'hFEDC_BA98_7654_3210;
    beat_vals[2] = 64'h0F0F_0F0F_0F0F_0F0F;
    beat_vals[3] = 64'hF0F0_F0F0_F0F0_F0F0;
    exp_b = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    drive_line(32'h0000_015F, 0, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (got !== exp_b) begin errors++; $display("FAIL spur_next_line got=%064h exp=%064h", got, exp_b); end
    checks++;
    if (ba !== 32'h0000_0140) begin errors++; $display("FAIL spur_next_addr got=%08h exp=00000140", ba); end
  endtask

  task automatic test_reset_mid_burst();
    int ra, rc, bb;
    logic [255:0] got, exp_line;
    logic [31:0]  ba;
    line_addr = 32'h0000_1234;
    line_read = 1'b1;
    @(negedge clk);
    burst_resp = 1'b1; burst_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    burst_rdata = 64'h6666_6666_6666_6666;
    @(negedge clk);
    rst_n = 1'b0; line_read = 1'b0;
    burst_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    checks++;
    if (burst_read !== 1'b0) begin errors++; $display("FAIL rst_mid_burst_read got=%b exp=0", burst_read); end
    checks++;
    if (line_rdata !== 256'h0) begin errors++; $display("FAIL rst_mid_rdata got=%064h exp=0", line_rdata); end
    rst_n = 1'b1;
    burst_rdata = 64'h8888_8888_8888_8888;
    repeat (2) @(negedge clk);
    burst_resp = 1'b0;
    checks++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
      errors++; $display("FAIL rst_late_beats got=resp%b/read%b exp=0/0", line_resp, burst_read);
    end
    $display("txn reset mid-burst: burst_read=%b line_rdata=%064h", burst_read, line_rdata);

    beat_vals[0] = 64'h0000_0000_0000_00A0;
    beat_vals[1] = 64'h0000_0000_0000_00A1;
    beat_vals[2] = 64'h0000_0000_0000_00A2;
    beat_vals[3] = 64'h0000_0000_0000_00A3;
    exp_line = {64'h0000_0000_0000_00A3, 64'h0000_0000_0000_00A2,
                64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00A0};
    drive_line(32'h0000_0040, 0, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (ba !== 32'h0000_0040) begin errors++; $display("FAIL rst_new_addr got=%08h exp=00000040", ba); end
    checks++;
    if (got !== exp_line || ra !== 5) begin
      errors++; $display("FAIL rst_new_line got=%064h@%0d exp=%064h@5", got, ra, exp_line);
    end
  endtask

  task automatic test_drop_mid_burst();
    int ra, rc, bb;
    logic [255:0] got, prev_line, exp_line;
    logic [31:0]  ba;
    prev_line = line_rdata;
    beat_vals[0] = 64'h9999_0000_0000_0000;
    beat_vals[1] = 64'h9999_1111_0000_0000;
    beat_vals[2] = 64'h9999_2222_0000_0000;
    beat_vals[3] = 64'h9999_3333_0000_0000;
    drive_line(32'h0000_2000, 0, 1, 1'b0, 1'b1, ra, rc, got, ba, bb);
    checks++;
    if (rc !== 0) begin errors++; $display("FAIL drop_no_resp got=%0d pulses exp=0", rc); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL drop_burst_read got=%0d bad cycles exp=0", bb); end
    checks++;
    if (line_rdata !== prev_line) begin errors++; $display("FAIL drop_rdata_hold got=%064h exp=%064h", line_rdata, prev_line); end

    // Request was re-raised while in DONE; it must be taken exactly when IDLE returns.
    beat_vals[0] = 64'hC0DE_0000_0000_0001;
    beat_vals[1] = 64'hC0DE_0000_0000_0002;
    beat_vals[2] = 64'hC0DE_0000_0000_0003;
    beat_vals[3] = 64'hC0DE_0000_0000_0004;
    exp_line = {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001};
    drive_line(32'h0000_2000, 0, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL drop_idle_timing got=%0d bad cycles exp=0", bb); end
    checks++;
    if (got !== exp_line || ra !== 5) begin
      errors++; $display("FAIL drop_next_line got=%064h@%0d exp=%064h@5", got, ra, exp_line);
    end
  endtask

  task automatic test_back_to_back();
    int ra, rc, bb;
    logic [255:0] got, exp_line;
    logic [31:0]  ba;
    beat_vals[0] = 64'h1000_0000_0000_0001;
    beat_vals[1] = 64'h2000_0000_0000_0002;
    beat_vals[2] = 64'h3000_0000_0000_0003;
    beat_vals[3] = 64'h4000_0000_0000_0004;
    exp_line = {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001};
    drive_line(32'hFFFF_FFFF, 1, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (ba !== 32'hFFFF_FFE0 || ra !== 9 || bb !== 0) begin
      errors++; $display("FAIL b2b_first got=addr%08h/resp%0d/bad%0d exp=ffffffe0/9/0", ba, ra, bb);
    end
    beat_vals[0] = 64'h0000_0000_0000_0010;
    beat_vals[1] = 64'h0000_0000_0000_0020;
    beat_vals[2] = 64'h0000_0000_0000_0030;
    beat_vals[3] = 64'h0000_0000_0000_0040;
    exp_line = {64'h0000_0000_0000_0040, 64'h0000_0000_0000_0030,
                64'h0000_0000_0000_0020, 64'h0000_0000_0000_0010};
    drive_line(32'h0000_0020, 0, 0, 1'b0, 1'b0, ra, rc, got, ba, bb);
    checks++;
    if (got !== exp_line || ra !== 5 || bb !== 0) begin
      errors++; $display("FAIL b2b_second got=%064h@%0d/bad%0d exp=%064h@5/0", got, ra, bb, exp_line);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_gapped_line();
    test_spurious();
    test_reset_mid_burst();
    test_drop_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
